mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: memArbiter

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: data port has priority, fetch gets a slot
// after a bounded streak of data grants; one-cycle read return.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iReq,
  input  logic [XLEN-1:0] iAddr,
  output logic            iGnt,
  output logic            iRValid,
  output logic [XLEN-1:0] iRData,
  input  logic            dReq,
  input  logic            dWe,
  input  logic [3:0]      dMask,
  input  logic [XLEN-1:0] dAddr,
  input  logic [XLEN-1:0] dWData,
  output logic            dGnt,
  output logic            dRValid,
  output logic [XLEN-1:0] dRData,
  output logic            dErr,
  output logic            mEn,
  output logic            mWe,
  output logic [3:0]      mMask,
  output logic [XLEN-1:0] mAddr,
  output logic [XLEN-1:0] mWData,
  input  logic [XLEN-1:0] mRData
);

  typedef enum logic [1:0] {
    OwnNone,
    OwnI,
    OwnD
  } owner_t;

  localparam logic [3:0] MaxStreak =
    4'(MAX_D_STREAK);
  localparam logic [XLEN-1:0] AlignMask =
    ~XLEN'(3);

  owner_t     ownerQ, ownerD;
  logic [3:0] streakQ, streakD;
  logic       errQ, errD;

  logic maskLegal;
  logic fault;
  logic dWin;
  logic dAcc;

  always_comb begin
    maskLegal = 1'b0;
    case (dMask)
      4'b0001, 4'b0010,
      4'b0100, 4'b1000,
      4'b0011, 4'b1100,
      4'b1111: maskLegal = 1'b1;
      default: maskLegal = 1'b0;
    endcase
  end

  assign fault =
    ((dMask == 4'b0011 || dMask == 4'b1100)
      && dAddr[0])
    || (dMask == 4'b1111 && dAddr[1:0] != 2'b00)
    || (dWe && !maskLegal);

  // Fetch only preempts once data has held it off long enough.
  assign dWin = !reset && dReq
    && !(iReq && streakQ == MaxStreak);
  assign dGnt = dWin;
  assign iGnt = !reset && iReq && !dWin;
  assign dAcc = dWin && !fault;
  assign mEn  = iGnt | dAcc;

  always_comb begin
    mAddr  = '0;
    mMask  = '0;
    mWData = '0;
    mWe    = 1'b0;
    unique case (1'b1)
      dAcc: begin
        mAddr  = dAddr & AlignMask;
        mMask  = dMask;
        mWe    = dWe;
        mWData = dWe ? dWData : '0;
      end
      iGnt: mAddr = iAddr & AlignMask;
      default: ;
    endcase
  end

  always_comb begin
    ownerD  = OwnNone;
    streakD = streakQ;
    errD    = dWin && fault;
    unique case (1'b1)
      iGnt:         ownerD = OwnI;
      dAcc && !dWe: ownerD = OwnD;
      default: ;
    endcase
    // A rejected request leaves the streak untouched.
    if (dWin && fault) begin
      streakD = streakQ;
    end else if (iGnt || !iReq) begin
      streakD = '0;
    end else if (dWin && streakQ < MaxStreak) begin
      streakD = streakQ + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ownerQ  <= OwnNone;
      streakQ <= '0;
      errQ    <= 1'b0;
    end else begin
      ownerQ  <= ownerD;
      streakQ <= streakD;
      errQ    <= errD;
    end
  end

  assign iRValid = (ownerQ == OwnI);
  assign dRValid = (ownerQ == OwnD);
  assign iRData  = iRValid ? mRData : '0;
  assign dRData  = dRValid ? mRData : '0;
  assign dErr    = errQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reference model plus a
// response scoreboard of expected one-cycle-later returns.
module tb_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk;
  logic        reset;
  logic        iReq;
  logic [31:0] iAddr;
  logic        iGnt;
  logic        iRValid;
  logic [31:0] iRData;
  logic        dReq;
  logic        dWe;
  logic [3:0]  dMask;
  logic [31:0] dAddr;
  logic [31:0] dWData;
  logic        dGnt;
  logic        dRValid;
  logic [31:0] dRData;
  logic        dErr;
  logic        mEn;
  logic        mWe;
  logic [3:0]  mMask;
  logic [31:0] mAddr;
  logic [31:0] mWData;
  logic [31:0] mRData;

  mem_arbiter #(
    .XLEN(32),
    .MAX_D_STREAK(MAXS)
  ) dut (
    .clk(clk), .reset(reset),
    .iReq(iReq), .iAddr(iAddr),
    .iGnt(iGnt), .iRValid(iRValid),
    .iRData(iRData),
    .dReq(dReq), .dWe(dWe),
    .dMask(dMask), .dAddr(dAddr),
    .dWData(dWData), .dGnt(dGnt),
    .dRValid(dRValid), .dRData(dRData),
    .dErr(dErr),
    .mEn(mEn), .mWe(mWe),
    .mMask(mMask), .mAddr(mAddr),
    .mWData(mWData), .mRData(mRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit i;
    bit d;
    bit e;
  } resp_t;

  resp_t sb[$];
  int    checks   = 0;
  int    failures = 0;
  int    streak   = 0;
  bit    lastI;
  bit    lastD;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h",
               tag, got, exp);
    end
  endtask

  function automatic bit isFault(
    input bit          we,
    input logic [3:0]  m,
    input logic [31:0] a
  );
    bit legal;
    legal = m inside {4'b0001, 4'b0010,
                      4'b0100, 4'b1000,
                      4'b0011, 4'b1100,
                      4'b1111};
    if ((m == 4'b0011 || m == 4'b1100) && a[0])
      return 1'b1;
    if (m == 4'b1111 && a[1:0] != 2'b00)
      return 1'b1;
    if (we && !legal)
      return 1'b1;
    return 1'b0;
  endfunction

  task automatic cyc(
    input bit          iR,
    input logic [31:0] iA,
    input bit          dR,
    input bit          dW,
    input logic [3:0]  dM,
    input logic [31:0] dA,
    input logic [31:0] dWd,
    input logic [31:0] rd
  );
    resp_t ex;
    bit    flt, eD, eI, eAcc, eEn;
    @(negedge clk);
    iReq = iR; iAddr = iA;
    dReq = dR; dWe = dW; dMask = dM;
    dAddr = dA; dWData = dWd;
    mRData = rd;
    #1;
    ex = '{1'b0, 1'b0, 1'b0};
    if (sb.size() > 0) ex = sb.pop_front();
    check("iRValid", 32'(iRValid), 32'(ex.i));
    check("iRData", iRData, ex.i ? rd : 32'h0);
    check("dRValid", 32'(dRValid), 32'(ex.d));
    check("dRData", dRData, ex.d ? rd : 32'h0);
    check("dErr", 32'(dErr), 32'(ex.e));
    flt  = isFault(dW, dM, dA);
    eD   = dR && !(iR && streak == MAXS);
    eI   = iR && !eD;
    eAcc = eD && !flt;
    eEn  = eI || eAcc;
    lastI = eI;
    lastD = eD;
    check("iGnt", 32'(iGnt), 32'(eI));
    check("dGnt", 32'(dGnt), 32'(eD));
    check("bothGnt", 32'(iGnt & dGnt), 32'h0);
    check("mEn", 32'(mEn), 32'(eEn));
    check("mWe", 32'(mWe), 32'(eAcc && dW));
    if (eEn) begin
      check("mMask", 32'(mMask),
            eAcc ? 32'(dM) : 32'h0);
      check("mAddr", mAddr,
            (eAcc ? dA : iA) & 32'hFFFF_FFFC);
    end
    if (eAcc && dW)
      check("mWData", mWData, dWd);
    sb.push_back('{eI, eAcc && !dW, eD && flt});
    if (eD && flt) streak = streak;
    else if (eI || !iR) streak = 0;
    else if (eD && streak < MAXS) streak++;
  endtask

  task automatic idle(input logic [31:0] rd);
    cyc(0, 0, 0, 0, 4'b0, 0, 0, rd);
  endtask

  task automatic checkQuiet(input string tag);
    check({tag, "_iGnt"}, 32'(iGnt), 0);
    check({tag, "_dGnt"}, 32'(dGnt), 0);
    check({tag, "_mEn"}, 32'(mEn), 0);
    check({tag, "_mWe"}, 32'(mWe), 0);
    check({tag, "_mMask"}, 32'(mMask), 0);
    check({tag, "_iRV"}, 32'(iRValid), 0);
    check({tag, "_dRV"}, 32'(dRValid), 0);
    check({tag, "_dErr"}, 32'(dErr), 0);
  endtask

  logic [3:0] rm;
  logic [3:0] masks [8];

  initial begin
    masks = '{4'b0001, 4'b0010, 4'b0100,
              4'b1000, 4'b0011, 4'b1100,
              4'b1111, 4'b0101};
    reset = 1'b1;
    iReq = 1'b1; iAddr = 32'h40;
    dReq = 1'b1; dWe = 1'b0;
    dMask = 4'b1111; dAddr = 32'h80;
    dWData = 0; mRData = 32'h1234;
    #3;
    checkQuiet("rst");
    @(posedge clk);
    #1 checkQuiet("rstClk");
    @(negedge clk);
    iReq = 0; dReq = 0;
    reset = 1'b0;

    cyc(1, 32'h100, 0, 0, 4'b0, 0, 0, 0);
    check("t40_iGnt", 32'(iGnt), 1);
    check("t40_mAddr", mAddr, 32'h100);
    check("t40_mWe", 32'(mWe), 0);
    idle(32'hDEAD_BEEF);
    check("t40_iRData", iRData, 32'hDEAD_BEEF);

    for (int k = 0; k < 6; k++) begin
      cyc(1, 32'h300 + 32'(4 * k), 1, 0,
          4'b1111, 32'h500 + 32'(4 * k),
          0, 32'hA000 + 32'(k));
      check("t41_dGnt", 32'(dGnt),
            32'(k != 4));
      check("t41_iGnt", 32'(iGnt),
            32'(k == 4));
    end
    idle(32'hA006);

    cyc(0, 0, 1, 1, 4'b1100, 32'h202,
        32'hAABB_0000, 0);
    check("t42_mWe", 32'(mWe), 1);
    check("t42_mAddr", mAddr, 32'h200);
    check("t42_mMask", 32'(mMask), 32'hC);
    check("t42_mWData", mWData, 32'hAABB_0000);
    idle(32'h5555);

    cyc(1, 32'h700, 1, 1, 4'b1111, 32'h102,
        32'h1, 0);
    check("t43_dGnt", 32'(dGnt), 1);
    check("t43_mEn", 32'(mEn), 0);
    check("t43_iGnt", 32'(iGnt), 0);
    idle(0);
    check("t43_dErr1", 32'(dErr), 1);
    idle(0);
    check("t43_dErr2", 32'(dErr), 0);
    cyc(0, 0, 1, 1, 4'b1100, 32'h203, 0, 0);
    cyc(0, 0, 1, 1, 4'b0101, 32'h204, 0, 0);
    cyc(0, 0, 1, 0, 4'b0011, 32'h209, 0, 0);
    cyc(0, 0, 1, 0, 4'b0000, 32'h20B, 0, 0);
    idle(32'h7777);

    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0)
        cyc(1, 32'h1000 + 32'(k), 0, 0,
            4'b0, 0, 0, 32'hB000 + 32'(k));
      else
        cyc(0, 0, 1, 0, 4'b1111,
            32'h2000 + 32'(4 * k), 0,
            32'hB000 + 32'(k));
      check("t45_gnt", 32'(iGnt | dGnt), 1);
    end
    idle(32'hB008);

    for (int k = 0; k < 60; k++) begin
      rm = masks[$urandom_range(7)];
      cyc(1'($urandom_range(1)), $urandom,
          1'($urandom_range(3) != 0),
          1'($urandom_range(1)), rm,
          $urandom, $urandom, $urandom);
    end
    idle(32'hC0C0);

    cyc(0, 0, 1, 0, 4'b1111, 32'h600, 0, 0);
    check("t44_dGnt", 32'(dGnt), 1);
    #2 reset = 1'b1;
    #1 checkQuiet("t44");
    check("t44_mAddr", mAddr, 0);
    @(posedge clk);
    @(negedge clk);
    iReq = 0; dReq = 0;
    reset = 1'b0;
    sb.delete();
    streak = 0;
    #1 check("t44_dRV0", 32'(dRValid), 0);
    idle(32'hFACE);
    check("t44_dRV1", 32'(dRValid), 0);
    cyc(0, 0, 1, 0, 4'b1111, 32'h604, 0, 0);
    check("t39_dGnt", 32'(dGnt), 1);
    idle(32'hF00D);
    check("t39_dRData", dRData, 32'hF00D);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
